// File: rtl/pmem_arb.sv
// ---------------------------------------------------------------------------
// pmem_arb -- program-memory arbiter
//
// Shares one single-port synchronous SRAM between an instruction-fetch
// requester (read only) and a loader requester (read or write). At most one
// access is issued per cycle. Grants are combinational, so a lone requester
// is served in the same cycle it asks. Read data returns one cycle after the
// grant, straight from the SRAM.
//
// Arbitration when both request, highest priority first:
//   1. a starved requester (wait count >= MAX_WAIT); fetch wins if both are
//   2. loader, if it owned the previous cycle and holds l_lock (burst)
//   3. round-robin: whoever did not own the previous cycle (fetch from IDLE)
//
// Optional build macro: PMEM_ARB_STATS_EN adds conflict_cnt / starve_cnt.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   f_req, f_addr                 fetch read request / address
//   f_gnt                         fetch accepted this cycle
//   f_rvalid, f_rdata             fetch read data (rdata holds when !rvalid)
//   l_req, l_we, l_lock           loader request, write enable, burst lock
//   l_addr, l_wdata               loader address / write data
//   l_gnt                         loader accepted this cycle
//   l_rvalid, l_rdata             loader read data (rdata holds when !rvalid)
//   m_en, m_we, m_addr, m_wdata   SRAM control
//   m_rdata                       SRAM read data (cycle after a read)
//   conflict_cnt, starve_cnt      statistics (PMEM_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module pmem_arb #(
    parameter int AW       = 11,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
`ifdef PMEM_ARB_STATS_EN
    output logic [15:0]   conflict_cnt,
    output logic [15:0]   starve_cnt,
`endif
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_F = 2'd1,
        OWN_L = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_TH = 4'(MAX_WAIT);

    state_t        state;
    logic [3:0]    f_wait;
    logic [3:0]    l_wait;
    logic [DW-1:0] f_hold;
    logic [DW-1:0] l_hold;

    logic          both_req;
    logic          f_starved;
    logic          l_starved;
    logic          f_win;
    logic          l_win;
    logic          starve_override;

    assign both_req  = f_req & l_req;
    assign f_starved = (f_wait >= WAIT_TH);
    assign l_starved = (l_wait >= WAIT_TH);

    // Winner selection. Everything is held off while reset is asserted so the
    // SRAM sees no access during reset.
    always_comb begin
        f_win           = 1'b0;
        l_win           = 1'b0;
        starve_override = 1'b0;
        if (!rst) begin
            if (both_req) begin
                if (f_starved) begin
                    f_win           = 1'b1;
                    starve_override = 1'b1;
                end else if (l_starved) begin
                    l_win           = 1'b1;
                    starve_override = 1'b1;
                end else if ((state == OWN_L) && l_lock) begin
                    l_win = 1'b1;
                end else if (state == OWN_F) begin
                    l_win = 1'b1;
                end else begin
                    f_win = 1'b1;
                end
            end else if (f_req) begin
                f_win = 1'b1;
            end else if (l_req) begin
                l_win = 1'b1;
            end
        end
    end

    assign f_gnt = f_win;
    assign l_gnt = l_win;

    // SRAM drive: address/data are zeroed when idle so the bus is quiet.
    assign m_en    = f_win | l_win;
    assign m_we    = l_win & l_we;
    assign m_addr  = f_win ? f_addr : (l_win ? l_addr : '0);
    assign m_wdata = (l_win && l_we) ? l_wdata : '0;

    // Read data comes straight from the SRAM in the valid cycle and is
    // captured so it stays visible afterwards.
    assign f_rdata = f_rvalid ? m_rdata : f_hold;
    assign l_rdata = l_rvalid ? m_rdata : l_hold;

    // Ownership FSM, starvation counters and read-return tracking. The state
    // remembers the last winner; a cycle without any grant returns it to IDLE.
    // Wait counters only run while their requester is actually kept waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            f_wait   <= 4'd0;
            l_wait   <= 4'd0;
            f_rvalid <= 1'b0;
            l_rvalid <= 1'b0;
            f_hold   <= '0;
            l_hold   <= '0;
        end else begin
            if (f_win) begin
                state <= OWN_F;
            end else if (l_win) begin
                state <= OWN_L;
            end else begin
                state <= IDLE;
            end

            if (f_req && !f_win) begin
                f_wait <= (f_wait == 4'hF) ? 4'hF : f_wait + 4'd1;
            end else begin
                f_wait <= 4'd0;
            end

            if (l_req && !l_win) begin
                l_wait <= (l_wait == 4'hF) ? 4'hF : l_wait + 4'd1;
            end else begin
                l_wait <= 4'd0;
            end

            f_rvalid <= f_win;
            l_rvalid <= l_win & ~l_we;

            if (f_rvalid) begin
                f_hold <= m_rdata;
            end
            if (l_rvalid) begin
                l_hold <= m_rdata;
            end
        end
    end

`ifdef PMEM_ARB_STATS_EN
    // Saturating statistics: cycles with both requesters active, and cycles
    // where a starvation override decided the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= 16'd0;
            starve_cnt   <= 16'd0;
        end else begin
            if (both_req && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (starve_override && (starve_cnt != 16'hFFFF)) begin
                starve_cnt <= starve_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/pmem_arb.md
PMEM_ARB -- requirements
Module: pmem_arb

Interface
REQ-001 Parameter AW, default 11, program-memory word-address width (2048 words).
REQ-002 Parameter DW, default 32, program-memory data width.
REQ-003 Parameter MAX_WAIT, default 8, starvation threshold in cycles (legal range 1..15).
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 f_req  input  1  fetch requester: read request, held until granted.
REQ-007 f_addr  input  AW  fetch read address.
REQ-008 f_gnt  output  1  fetch request accepted this cycle (combinational).
REQ-009 f_rvalid / f_rdata  output  1 / DW  fetch read data valid, one cycle after grant.
REQ-010 l_req / l_we / l_lock  input  1 each  loader request, write enable, bus-lock hint.
REQ-011 l_addr / l_wdata  input  AW / DW  loader address and write data.
REQ-012 l_gnt  output  1  loader request accepted this cycle (combinational).
REQ-013 l_rvalid / l_rdata  output  1 / DW  loader read data valid, one cycle after a read grant.
REQ-014 m_en / m_we / m_addr / m_wdata  output  1 / 1 / AW / DW  single-port synchronous SRAM control.
REQ-015 m_rdata  input  DW  SRAM read data, valid the cycle after m_en with m_we=0.

Function
REQ-016 The block SHALL issue at most one memory access per cycle; f_gnt and l_gnt SHALL never both be 1.
REQ-017 A grant SHALL drive m_en=1 with the winner's address/data in the same cycle; with no grant, m_en=0 and m_we=0.
REQ-018 f_rvalid (l_rvalid) SHALL be 1 exactly one cycle after an f_gnt (l_gnt with l_we=0), with rdata = m_rdata; l_rvalid SHALL remain 0 after write grants.
REQ-019 rdata outputs SHALL hold their last value when rvalid=0.
REQ-020 Ownership FSM states: IDLE, OWN_F, OWN_L; state SHALL record the last winner, returning to IDLE after a cycle with no request.
REQ-021 Single requester: it SHALL be granted in the same cycle, regardless of state.
REQ-022 Both requesting, default: round-robin; the requester not owning the previous cycle wins (from IDLE, fetch wins).
REQ-023 Both requesting, state OWN_L and l_lock=1: loader SHALL win (burst), subject to REQ-025.
REQ-024 Per-requester 4-bit wait counter SHALL increment each cycle req=1 and gnt=0, saturate at 15, and clear on grant or when req=0.
REQ-025 A requester whose wait counter is >= MAX_WAIT SHALL win over lock and round-robin; if both are starved, fetch wins.
REQ-026 Request inputs sampled only when req=1; changing address while waiting SHALL be allowed and the value at grant SHALL be used.

Reset
REQ-027 Asserting rst SHALL immediately force: state IDLE, wait counters 0, f_rvalid=0, l_rvalid=0, f_rdata=0, l_rdata=0.
REQ-028 While rst=1, f_gnt, l_gnt, m_en and m_we SHALL be 0; m_addr and m_wdata SHALL be 0.
REQ-029 Reset asserted with a read in flight SHALL suppress that read's rvalid; first grant possible in the first cycle after rst deasserts.

Configuration
REQ-030 Macro PMEM_ARB_STATS_EN defined: outputs conflict_cnt (16-bit, increments every cycle both req=1, saturates at 0xFFFF) and starve_cnt (16-bit, increments on each REQ-025 override, saturates), both reset to 0.
REQ-031 Macro undefined: those ports and counters SHALL not exist; arbitration behaviour SHALL be identical.

Verification
REQ-032 After reset, f_req=1, f_addr=0x000, SRAM word0=0xF0000100 -> f_gnt=1 same cycle, f_rvalid=1, f_rdata=0xF0000100 next cycle.
REQ-033 f_req and l_req (read) both held from IDLE -> grants alternate F,L,F,L; m_en=1 every cycle.
REQ-034 l_lock=1, l_we=1, 20-word write burst, f_req held -> loader wins cycles 1..8 after OWN_L, f_gnt=1 on the cycle fetch wait count reaches 8 (MAX_WAIT=8), then loader resumes.
REQ-035 Loader writes 0x18992000 to addr 0x002, then fetch reads 0x002 -> f_rdata=0x18992000, l_rvalid stays 0 for the write.
REQ-036 rst pulsed on the cycle after an f_gnt -> f_rvalid stays 0, all outputs at reset values, normal grants resume the cycle after release.
REQ-037 With PMEM_ARB_STATS_EN, 10 cycles of simultaneous requests without lock -> conflict_cnt=10, starve_cnt=0.
